bit_packer: RTL and testbench

Variable-length bit packer: the transmit-side counterpart of the `bits` unpacker. Upstream pushes fields of 0–15 bits; the block concatenates them MSB-first into 32-bit words and queues the words for downstream. A flush pads the residual bits with zeros and marks the last word. Its output feeds any 32-bit word sink, including a `bits` instance.

---
 rtl/bit_packer_if.sv | 25 ++
 rtl/bit_packer.sv | 132 +++++++++++++
 tb/tb_bit_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_packer_if.sv
// Field/word handshake bundle for bit_packer.
// master is the upstream/downstream side, slave is the packer.
interface bit_packer_if;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flushin;
    logic        stallin;
    logic        fullout;
    logic        pushout;
    logic [31:0] dataout;
    logic        lastout;
    logic [5:0]  bitsout;
    logic        overflow;

    modport master (
        output pushin, lenin, datain, flushin, stallin,
        input  fullout, pushout, dataout, lastout, bitsout, overflow
    );

    modport slave (
        input  pushin, lenin, datain, flushin, stallin,
        output fullout, pushout, dataout, lastout, bitsout, overflow
    );
endinterface

// File: rtl/bit_packer.sv
// Variable-length bit packer: MSB-first concatenation of 0-15 bit
// fields into 32-bit words, queued for a downstream word sink.
module bit_packer #(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    bit_packer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [46:0]   acc_q, acc_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] used_q;
    logic          ovf_q;

    logic [31:0]   mem_data_q [DEPTH];
    logic          mem_last_q [DEPTH];
    logic [5:0]    mem_bits_q [DEPTH];

    logic          q_full, q_empty, full, pop;
    logic          accept_push, accept_flush;
    logic [14:0]   field;
    logic [46:0]   merged;
    logic [5:0]    sum;
    logic          wr_en, wr_last;
    logic [31:0]   wr_data;
    logic [5:0]    wr_bits;

    always_comb begin
        q_full       = (used_q == FULL_C);
        q_empty      = (used_q == '0);
        full         = q_full | (state_q == FLUSH);
        pop          = !q_empty & !bus.stallin;
        accept_push  = bus.pushin & !full;
        accept_flush = bus.flushin & !full;
        field        = bus.datain & ~(15'h7fff << bus.lenin);
        // left-align the field, then drop it just below the valid bits
        merged = acc_q |
                 (({field, 32'd0} << (4'd15 - bus.lenin)) >> cnt_q);
        sum    = cnt_q + {2'b00, bus.lenin};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_bits = 6'd32;
        wr_data = acc_q[46:15];
        unique case (state_q)
            RUN: begin
                if (accept_push) begin
                    acc_d = merged;
                    cnt_d = sum;
                end
                if (cnt_d >= 6'd32) begin
                    wr_en   = 1'b1;
                    wr_data = acc_d[46:15];
                    acc_d   = acc_d << 32;
                    cnt_d   = cnt_d - 6'd32;
                end
                if (accept_flush) state_d = FLUSH;
            end
            FLUSH: begin
                if (!q_full) begin
                    if (cnt_q >= 6'd32) begin
                        wr_en = 1'b1;
                        acc_d = acc_q << 32;
                        cnt_d = cnt_q - 6'd32;
                    end else begin
                        state_d = RUN;
                        if (cnt_q != 6'd0) begin
                            wr_en   = 1'b1;
                            wr_last = 1'b1;
                            wr_bits = cnt_q;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            used_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (wr_en) wptr_q <= wptr_q + AW'(1);
            if (pop)   rptr_q <= rptr_q + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   used_q <= used_q + CW'(1);
                2'b01:   used_q <= used_q - CW'(1);
                default: used_q <= used_q;
            endcase
            if ((bus.pushin | bus.flushin) & full) ovf_q <= 1'b1;
        end
    end

    // storage needs no reset: the empty flag gates the head
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_data_q[wptr_q] <= wr_data;
            mem_last_q[wptr_q] <= wr_last;
            mem_bits_q[wptr_q] <= wr_bits;
        end
    end

    assign bus.fullout  = full;
    assign bus.pushout  = pop;
    assign bus.dataout  = q_empty ? 32'd0 : mem_data_q[rptr_q];
    assign bus.lastout  = q_empty ? 1'b0  : mem_last_q[rptr_q];
    assign bus.bitsout  = q_empty ? 6'd0  : mem_bits_q[rptr_q];
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bit_packer.sv
// Directed vector table plus randomized run against a bit-queue model
// of the packer.
module tb_bit_packer;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    bit_packer_if bus();

    bit_packer #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [5:0]  b;
    } word_t;

    typedef struct {
        bit          p;
        logic [3:0]  l;
        logic [14:0] d;
        bit          f;
        bit          s;
        bit          po;
        logic [31:0] dat;
        bit          la;
        logic [5:0]  bi;
        bit          fu;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    // reference model: pending bits, queued words, flush flag
    bit    bq[$];
    word_t wq[$];
    bit    m_flush;
    bit    m_ovf;
    bit    mon_en = 0;

    bit          c_rs, c_p, c_f, c_s;
    logic [3:0]  c_l;
    logic [14:0] c_d;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_full();
        return (wq.size() == DEPTH) || m_flush;
    endfunction

    task automatic take_word(input bit last_flag, output word_t w);
        int n;
        n = (bq.size() < 32) ? bq.size() : 32;
        w.d = '0;
        for (int k = 0; k < n; k++) w.d[31-k] = bq[k];
        repeat (n) void'(bq.pop_front());
        w.l = last_flag;
        w.b = 6'(n);
    endtask

    task automatic model_check();
        word_t h;
        h = '{32'd0, 1'b0, 6'd0};
        if (wq.size() != 0) h = wq[0];
        chk("m_fullout", {31'd0, bus.fullout}, {31'd0, m_full()});
        chk("m_pushout", {31'd0, bus.pushout},
            {31'd0, (wq.size() != 0) && !c_s});
        chk("m_dataout", bus.dataout, h.d);
        chk("m_lastout", {31'd0, bus.lastout}, {31'd0, h.l});
        chk("m_bitsout", {26'd0, bus.bitsout}, {26'd0, h.b});
        chk("m_overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    endtask

    task automatic model_update();
        bit    full, po, have;
        word_t nw;
        int    n;
        if (c_rs) begin
            bq.delete();
            wq.delete();
            m_flush = 0;
            m_ovf   = 0;
            return;
        end
        full = m_full();
        po   = (wq.size() != 0) && !c_s;
        have = 0;
        if (!m_flush) begin
            if (c_p && !full) begin
                n = c_l;
                for (int i = n - 1; i >= 0; i--) bq.push_back(c_d[i]);
            end
            if (bq.size() >= 32) begin
                take_word(0, nw);
                have = 1;
            end
            if (c_f && !full) m_flush = 1;
        end else if (wq.size() < DEPTH) begin
            if (bq.size() >= 32) begin
                take_word(0, nw);
                have = 1;
            end else begin
                if (bq.size() > 0) begin
                    take_word(1, nw);
                    have = 1;
                end
                m_flush = 0;
            end
        end
        if ((c_p || c_f) && full) m_ovf = 1;
        if (po) void'(wq.pop_front());
        if (have) wq.push_back(nw);
    endtask

    task automatic drive(input bit rs, input bit p, input logic [3:0] l,
                         input logic [14:0] d, input bit f, input bit s);
        @(negedge clock);
        reset       = rs;
        bus.pushin  = p;
        bus.lenin   = l;
        bus.datain  = d;
        bus.flushin = f;
        bus.stallin = s;
        c_rs = rs; c_p = p; c_l = l; c_d = d; c_f = f; c_s = s;
        #1;
        if (mon_en) model_check();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
    endtask

    task automatic step(input bit p, input logic [3:0] l,
                        input logic [14:0] d, input bit f, input bit s);
        drive(0, p, l, d, f, s);
        advance();
    endtask

    task automatic add(input bit p, input logic [3:0] l,
                       input logic [14:0] d, input bit f, input bit po,
                       input logic [31:0] dat, input bit la,
                       input logic [5:0] bi, input bit fu);
        vec_t v;
        v = '{p, l, d, f, 1'b0, po, dat, la, bi, fu};
        tbl.push_back(v);
    endtask

    initial begin
        // 8 nibbles -> 0x12345678
        for (int i = 0; i < 8; i++)
            add(1, 4, 15'(i + 1), 0, 0, 0, 0, 6'd0, 0);
        add(0, 0, 0, 0, 1, 32'h12345678, 0, 6'd32, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'd0, 0);
        // 45 ones then flush
        for (int i = 0; i < 3; i++)
            add(1, 15, 15'h7fff, 0, 0, 0, 0, 6'd0, 0);
        add(0, 0, 0, 1, 1, 32'hffffffff, 0, 6'd32, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'd0, 1);
        add(0, 0, 0, 0, 1, 32'hfff80000, 1, 6'd13, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'd0, 0);
        // masked upper bits and zero-length field
        add(1, 3, 15'h7fff, 0, 0, 0, 0, 6'd0, 0);
        add(1, 0, 15'h1234, 0, 0, 0, 0, 6'd0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 6'd0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'd0, 1);
        add(0, 0, 0, 0, 1, 32'he0000000, 1, 6'd3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'd0, 0);
        // push and flush together with count = 20
        add(1, 10, 15'h0, 0, 0, 0, 0, 6'd0, 0);
        add(1, 10, 15'h0, 0, 0, 0, 0, 6'd0, 0);
        add(1, 15, 15'h7fff, 1, 0, 0, 0, 6'd0, 0);
        add(0, 0, 0, 0, 1, 32'h00000fff, 0, 6'd32, 1);
        add(0, 0, 0, 0, 1, 32'he0000000, 1, 6'd3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'd0, 0);

        drive(1, 0, 0, 0, 0, 0);
        advance();
        drive(1, 0, 0, 0, 0, 0);
        advance();
        mon_en = 1;
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_pushout", {31'd0, bus.pushout}, 32'd0);
        chk("rst_dataout", bus.dataout, 32'd0);
        chk("rst_fullout", {31'd0, bus.fullout}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        advance();

        foreach (tbl[i]) begin
            drive(0, tbl[i].p, tbl[i].l, tbl[i].d, tbl[i].f, tbl[i].s);
            chk($sformatf("v%0d_pushout", i),
                {31'd0, bus.pushout}, {31'd0, tbl[i].po});
            chk($sformatf("v%0d_dataout", i), bus.dataout, tbl[i].dat);
            chk($sformatf("v%0d_lastout", i),
                {31'd0, bus.lastout}, {31'd0, tbl[i].la});
            chk($sformatf("v%0d_bitsout", i),
                {26'd0, bus.bitsout}, {26'd0, tbl[i].bi});
            chk($sformatf("v%0d_fullout", i),
                {31'd0, bus.fullout}, {31'd0, tbl[i].fu});
            advance();
        end

        // stalled sink: queue fills, further pushes drop
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, 4, 15'hf, 0, 1);
            chk("st_fullout", {31'd0, bus.fullout}, {31'd0, i >= 32});
            advance();
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("st_overflow", {31'd0, bus.overflow}, 32'd1);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("dr_pushout", {31'd0, bus.pushout}, 32'd1);
            chk("dr_dataout", bus.dataout, 32'hffffffff);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("dr_empty", {31'd0, bus.pushout}, 32'd0);
        advance();
        for (int i = 0; i < 8; i++) step(1, 4, 15'(i + 1), 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap_dataout", bus.dataout, 32'h12345678);
        advance();

        // reset with 3 queued words, 17 residual bits, in FLUSH
        for (int i = 0; i < 7; i++) step(1, 15, 15'h7fff, 0, 1);
        step(1, 8, 15'hff, 0, 1);
        step(0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 1);
        chk("pre_rst_fullout", {31'd0, bus.fullout}, 32'd1);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        chk("prst_pushout", {31'd0, bus.pushout}, 32'd0);
        chk("prst_dataout", bus.dataout, 32'd0);
        chk("prst_lastout", {31'd0, bus.lastout}, 32'd0);
        chk("prst_bitsout", {26'd0, bus.bitsout}, 32'd0);
        chk("prst_fullout", {31'd0, bus.fullout}, 32'd0);
        chk("prst_overflow", {31'd0, bus.overflow}, 32'd0);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("prst_noword", {31'd0, bus.pushout}, 32'd0);
            advance();
        end
        step(1, 4, 15'ha, 0, 0);
        step(1, 4, 15'hb, 0, 0);
        step(1, 4, 15'hc, 0, 0);
        step(1, 4, 15'hd, 0, 0);
        step(1, 4, 15'he, 0, 0);
        step(1, 4, 15'hf, 0, 0);
        step(1, 4, 15'h0, 0, 0);
        step(1, 4, 15'h1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("prst_word", bus.dataout, 32'habcdef01);
        chk("prst_bits", {26'd0, bus.bitsout}, 32'd32);
        advance();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 700) == 0,
                  ($urandom % 4) != 0,
                  4'($urandom),
                  15'($urandom),
                  ($urandom % 12) == 0,
                  ($urandom % 3) == 0);
            advance();
        end
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
